// File: rtl/counter_pkg.sv
// counter_pkg: shared 7-segment constants and hex decode helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
// Contents: SEG_0..SEG_F active-high segment patterns (bit0=a .. bit6=g, bit7=dp left 0),
//           hex_to_seg() mapping a nibble to its pattern without the decimal point.
package counter_pkg;

  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;
  localparam logic [7:0] SEG_A = 8'h77;
  localparam logic [7:0] SEG_B = 8'h7C;
  localparam logic [7:0] SEG_C = 8'h39;
  localparam logic [7:0] SEG_D = 8'h5E;
  localparam logic [7:0] SEG_E = 8'h79;
  localparam logic [7:0] SEG_F = 8'h71;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
    logic [7:0] pat;
    case (hex)
      4'h0:    pat = SEG_0;
      4'h1:    pat = SEG_1;
      4'h2:    pat = SEG_2;
      4'h3:    pat = SEG_3;
      4'h4:    pat = SEG_4;
      4'h5:    pat = SEG_5;
      4'h6:    pat = SEG_6;
      4'h7:    pat = SEG_7;
      4'h8:    pat = SEG_8;
      4'h9:    pat = SEG_9;
      4'hA:    pat = SEG_A;
      4'hB:    pat = SEG_B;
      4'hC:    pat = SEG_C;
      4'hD:    pat = SEG_D;
      4'hE:    pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: hex nibble to 7-segment pattern (segments a..g, active high).
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: hex (in, 4) nibble to show; seg (out, 7) bit0=a .. bit6=g.
module seg7_decoder
  import counter_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // The helper's bit 7 (decimal point) is always 0; only a..g leave this block.
  assign seg = 7'(hex_to_seg(hex));

endmodule

// File: rtl/updown_counter_7seg.sv
// updown_counter_7seg: prescaled up/down counter, wrap or saturate, tc pulse, hex display.
// Latency: count/tc update one edge after a load or step; at_limit/SEG follow count combinationally.
// Backpressure: none; enable gates the prescaler, load overrides stepping for that edge.
// Ports: clk_2, reset (async, active high), load/data_in, enable, up, sat_mode in;
//        count (registered), tc (registered pulse), at_limit (comb), SEG (dp = at_limit) out.
module updown_counter_7seg
  import counter_pkg::*;
#(
  parameter int NBITS     = 4,
  parameter int MAX_COUNT = 2**NBITS - 1,
  parameter int TICK_DIV  = 1
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             load,
  input  logic [NBITS-1:0] data_in,
  input  logic             enable,
  input  logic             up,
  input  logic             sat_mode,
  output logic [NBITS-1:0] count,
  output logic             tc,
  output logic             at_limit,
  output logic [7:0]       SEG
);

  // Prescaler needs at least one bit even when every enabled cycle is a step.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(TICK_DIV - 1);
  // Limits are held one bit wider so comparisons never rely on natural overflow.
  localparam logic [NBITS:0] MAX_EXT = (NBITS + 1)'(MAX_COUNT);

  logic [PW-1:0]  prescaler;
  logic [NBITS:0] count_ext;
  logic [NBITS:0] data_ext;
  logic [NBITS-1:0] load_val;
  logic [NBITS-1:0] step_val;
  logic           step_at_limit;
  logic           step_now;
  logic [6:0]     seg_abc;

  assign count_ext = {1'b0, count};
  assign data_ext  = {1'b0, data_in};
  assign step_now  = (prescaler == PS_LAST);

  // Out-of-range load values clamp to the top of the range.
  assign load_val = (data_ext > MAX_EXT) ? NBITS'(MAX_COUNT) : data_in;

  // Next count for a step edge; a blocked or wrapping step raises step_at_limit.
  always_comb begin
    step_val      = count;
    step_at_limit = 1'b0;
    if (up) begin
      if (count_ext < MAX_EXT) begin
        step_val = NBITS'(count_ext + 1'b1);
      end else begin
        step_at_limit = 1'b1;
        step_val      = sat_mode ? count : '0;
      end
    end else begin
      if (count_ext != '0) begin
        step_val = NBITS'(count_ext - 1'b1);
      end else begin
        step_at_limit = 1'b1;
        step_val      = sat_mode ? count : NBITS'(MAX_COUNT);
      end
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      count     <= '0;
      tc        <= 1'b0;
      prescaler <= '0;
    end else if (load) begin
      count     <= load_val;
      tc        <= 1'b0;
      prescaler <= '0;
    end else if (enable) begin
      if (step_now) begin
        prescaler <= '0;
        count     <= step_val;
        tc        <= step_at_limit;
      end else begin
        prescaler <= prescaler + 1'b1;
        tc        <= 1'b0;
      end
    end else begin
      // Any gap in enable restarts the step period.
      prescaler <= '0;
      tc        <= 1'b0;
    end
  end

  assign at_limit = up ? (count_ext == MAX_EXT) : (count_ext == '0);

  seg7_decoder u_seg7_decoder (
    .hex (count[3:0]),
    .seg (seg_abc)
  );

  assign SEG = {at_limit, seg_abc};

endmodule

// File: tb/tb_updown_counter_7seg.sv
module tb_updown_counter_7seg;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] data_in;
  logic       enable;
  logic       up;
  logic       sat_mode;

  logic [3:0] count0, count1, count2;
  logic       tc0, tc1, tc2;
  logic       al0, al1, al2;
  logic [7:0] seg0, seg1, seg2;

  int checks   = 0;
  int failures = 0;

  // Reference model state, one entry per instance.
  int mc[3];
  int mp[3];
  int mt[3];
  int MAXC[3] = '{15, 9, 15};
  int DIVS[3] = '{1, 1, 3};
  logic [7:0] SEGT[16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                           8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  always #5 clk_2 = ~clk_2;

  updown_counter_7seg #(.NBITS(4), .TICK_DIV(1)) u_dut0 (
    .clk_2(clk_2), .reset(reset), .load(load), .data_in(data_in), .enable(enable),
    .up(up), .sat_mode(sat_mode), .count(count0), .tc(tc0), .at_limit(al0), .SEG(seg0));

  updown_counter_7seg #(.NBITS(4), .MAX_COUNT(9), .TICK_DIV(1)) u_dut1 (
    .clk_2(clk_2), .reset(reset), .load(load), .data_in(data_in), .enable(enable),
    .up(up), .sat_mode(sat_mode), .count(count1), .tc(tc1), .at_limit(al1), .SEG(seg1));

  updown_counter_7seg #(.NBITS(4), .TICK_DIV(3)) u_dut2 (
    .clk_2(clk_2), .reset(reset), .load(load), .data_in(data_in), .enable(enable),
    .up(up), .sat_mode(sat_mode), .count(count2), .tc(tc2), .at_limit(al2), .SEG(seg2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mc[i] = 0; mp[i] = 0; mt[i] = 0;
    end
  endtask

  // One rising edge of the reference: counting is modular over 0..MAXC.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        mc[i] = 0; mp[i] = 0; mt[i] = 0;
      end else if (load) begin
        mc[i] = (int'(data_in) > MAXC[i]) ? MAXC[i] : int'(data_in);
        mp[i] = 0; mt[i] = 0;
      end else if (!enable) begin
        mp[i] = 0; mt[i] = 0;
      end else if (mp[i] + 1 < DIVS[i]) begin
        mp[i]++; mt[i] = 0;
      end else begin
        int lim;
        mp[i] = 0;
        lim = up ? (mc[i] == MAXC[i]) : (mc[i] == 0);
        mt[i] = lim;
        if (!(lim && sat_mode))
          mc[i] = (mc[i] + (up ? 1 : MAXC[i])) % (MAXC[i] + 1);
      end
    end
  endtask

  task automatic check_inst(input int i, input logic [3:0] c, input logic t,
                            input logic al, input logic [7:0] s);
    logic       e_al;
    logic [3:0] cn;
    cn   = 4'(mc[i]);
    e_al = up ? (mc[i] == MAXC[i]) : (mc[i] == 0);
    check($sformatf("count%0d", i), 32'(c), 32'(mc[i]));
    check($sformatf("tc%0d", i), 32'(t), 32'(mt[i]));
    check($sformatf("at_limit%0d", i), 32'(al), 32'(e_al));
    check($sformatf("seg%0d", i), 32'(s), 32'(SEGT[cn] | {e_al, 7'b0}));
  endtask

  task automatic check_all();
    check_inst(0, count0, tc0, al0, seg0);
    check_inst(1, count1, tc1, al1, seg1);
    check_inst(2, count2, tc2, al2, seg2);
  endtask

  task automatic cycle();
    @(posedge clk_2);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; data_in = 4'd0; enable = 1'b0; up = 1'b1; sat_mode = 1'b0;
    model_reset();
    #2;
    check("rst_count", 32'(count0), 32'd0);
    check("rst_tc", 32'(tc0), 32'd0);
    check("rst_seg", 32'(seg0), 32'h3F);
    check_all();
    cycle();
    reset = 1'b0;

    // Count up three steps.
    enable = 1'b1;
    repeat (3) cycle();
    check("up3_count", 32'(count0), 32'd3);
    check("up3_seg", 32'(seg0), 32'h4F);

    // Wrap up from 15 and down from 0.
    load = 1'b1; data_in = 4'd15;
    cycle();
    load = 1'b0;
    cycle();
    check("wrap_up_count", 32'(count0), 32'd0);
    check("wrap_up_tc", 32'(tc0), 32'd1);
    enable = 1'b0;
    cycle();
    check("wrap_up_tc_drop", 32'(tc0), 32'd0);
    enable = 1'b1; up = 1'b0;
    cycle();
    check("wrap_dn_count", 32'(count0), 32'd15);
    check("wrap_dn_seg", 32'(seg0), 32'h71);
    check("wrap_dn_tc", 32'(tc0), 32'd1);

    // Saturate at 15 with up: every blocked step pulses tc.
    up = 1'b1; sat_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("sat_count", 32'(count0), 32'd15);
      check("sat_tc", 32'(tc0), 32'd1);
      check("sat_dp", 32'(seg0[7]), 32'd1);
    end

    // Load beats enable; clamp to MAX_COUNT on the modulus-10 instance.
    load = 1'b1; data_in = 4'd9;
    cycle();
    check("load9_count", 32'(count0), 32'd9);
    check("load9_tc", 32'(tc0), 32'd0);
    data_in = 4'd12;
    cycle();
    check("load12_clamp", 32'(count1), 32'd9);
    check("load12_plain", 32'(count0), 32'd12);

    // Prescaler of 3: seven enabled cycles give two steps.
    data_in = 4'd0; enable = 1'b0;
    cycle();
    load = 1'b0; enable = 1'b1; sat_mode = 1'b0;
    repeat (7) cycle();
    check("div3_count", 32'(count2), 32'd2);
    // Two enabled, one gap, then the step needs three fresh enabled cycles.
    enable = 1'b0;
    cycle();
    enable = 1'b1;
    repeat (2) cycle();
    enable = 1'b0;
    cycle();
    enable = 1'b1;
    repeat (2) cycle();
    check("div3_gap_hold", 32'(count2), 32'd2);
    cycle();
    check("div3_gap_step", 32'(count2), 32'd3);

    // Asynchronous reset mid-period.
    load = 1'b1; data_in = 4'd7;
    cycle();
    load = 1'b0;
    cycle();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("arst_count2", 32'(count2), 32'd0);
    check("arst_count0", 32'(count0), 32'd0);
    cycle();
    #2;
    reset = 1'b0;
    repeat (2) cycle();
    check("post_rst_hold", 32'(count2), 32'd0);
    cycle();
    check("post_rst_step", 32'(count2), 32'd1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      load     = ($urandom_range(15) == 0);
      enable   = ($urandom_range(7) != 0);
      up       = 1'($urandom);
      sat_mode = ($urandom_range(3) == 0);
      data_in  = 4'($urandom);
      if ($urandom_range(63) == 0) begin
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        cycle();
        #2;
        reset = 1'b0;
      end else begin
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
